usb_input_unpacker: RTL

Receive-side counterpart of the FFT output path: accepts the host byte stream, re-assembles 32-bit complex samples {re[15:0], im[15:0]}, buffers them in a small synchronous FIFO and presents them to the FFT input with a valid/ready handshake and frame markers. Byte order is least-significant byte first, the same order the output path emits: byte0=im[7:0], byte1=im[15:8], byte2=re[7:0], byte3=re[15:8]. The block sits between the USB receive interface and the FFT core, entirely in the FFT clock domain.

---
 rtl/usb_input_unpacker_pkg.sv | 18 +
 rtl/usb_input_unpacker_if.sv | 32 +++
 rtl/usb_input_unpacker_sync_fifo.sv | 60 ++++++
 rtl/usb_input_unpacker.sv | 113 +++++++++++
 4 files changed

// File: rtl/usb_input_unpacker_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_io_pkg: sample format shared by the FFT input and output byte paths
// Rev 1.0
// ----------------------------------------------------------------------------
package fft_io_pkg;

    localparam int SAMPLE_W         = 16;
    localparam int BYTES_PER_SAMPLE = 4;
    localparam int CPLX_W           = 2 * SAMPLE_W;

    typedef struct packed {
        logic [SAMPLE_W-1:0] re;
        logic [SAMPLE_W-1:0] im;
    } cplx_t;

endpackage
`default_nettype wire

// File: rtl/usb_input_unpacker_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// usb_input_unpacker_if: byte-in / sample-out handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface usb_input_unpacker_if;
    import fft_io_pkg::*;

    logic [7:0]          byte_in;
    logic                byte_valid;
    logic                byte_rd;
    logic [SAMPLE_W-1:0] data_out_re;
    logic [SAMPLE_W-1:0] data_out_im;
    logic                data_valid;
    logic                data_rd;
    logic                frame_last;
    logic                buff_full;
    logic                buff_empty;

    modport slave (
        input  byte_in, byte_valid, data_rd,
        output byte_rd, data_out_re, data_out_im, data_valid,
               frame_last, buff_full, buff_empty
    );

    modport master (
        output byte_in, byte_valid, data_rd,
        input  byte_rd, data_out_re, data_out_im, data_valid,
               frame_last, buff_full, buff_empty
    );
endinterface
`default_nettype wire

// File: rtl/usb_input_unpacker_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo: single-clock FIFO with fall-through read data and registered count
// Rev 1.0
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  wire logic                     CLK,
    input  wire logic                     reset,
    input  wire logic                     wr_en,
    input  wire logic [WIDTH-1:0]         din,
    input  wire logic                     rd_en,
    output logic      [WIDTH-1:0]         dout,
    output logic      [$clog2(DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_wr;
    logic             w_rd;

    assign w_wr = wr_en && !full;
    assign w_rd = rd_en && !empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == C_DEPTH);
    assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/usb_input_unpacker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// usb_input_unpacker: LSB-first byte stream -> buffered {re,im} samples + frame marker
// Rev 1.0
// ----------------------------------------------------------------------------
module usb_input_unpacker
    import fft_io_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 1024
) (
    input  wire logic            CLK,
    input  wire logic            reset,
    usb_input_unpacker_if.slave  bus
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FCW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int HOLD_W = 8 * (BYTES_PER_SAMPLE - 1);
    localparam logic [1:0]     C_IDX_LAST   = 2'(BYTES_PER_SAMPLE - 1);
    localparam logic [FCW-1:0] C_FRAME_LAST = FCW'(FRAME_LEN - 1);

    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    cplx_t             out_q, out_d;
    logic              valid_q, valid_d;
    logic [FCW-1:0]    frame_q, frame_d;

    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [CPLX_W-1:0] w_fifo_dout;
    logic              w_accept;
    logic              w_wr;
    logic              w_xfer;
    logic              w_load;

    // Any byte is refused while full, so a sample never sits half-assembled
    // waiting on a slot.
    assign w_accept = bus.byte_valid && !w_full;
    assign w_wr     = w_accept && (byte_idx_q == C_IDX_LAST);
    assign w_xfer   = valid_q && bus.data_rd;
    assign w_load   = (!valid_q || bus.data_rd) && (w_count != '0);

    sync_fifo #(
        .WIDTH (CPLX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .wr_en (w_wr),
        .din   ({bus.byte_in, hold_q}),
        .rd_en (w_load),
        .dout  (w_fifo_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        byte_idx_d = byte_idx_q;
        hold_d     = hold_q;
        out_d      = out_q;
        valid_d    = valid_q;
        frame_d    = frame_q;

        if (w_accept) begin
            byte_idx_d = byte_idx_q + 1'b1;
            case (byte_idx_q)
                2'd0:    hold_d[7:0]   = bus.byte_in;
                2'd1:    hold_d[15:8]  = bus.byte_in;
                2'd2:    hold_d[23:16] = bus.byte_in;
                default: ;
            endcase
        end

        if (w_load) begin
            out_d   = cplx_t'(w_fifo_dout);
            valid_d = 1'b1;
        end else if (w_xfer) begin
            valid_d = 1'b0;
        end

        if (w_xfer) begin
            frame_d = (frame_q == C_FRAME_LAST) ? '0 : frame_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            byte_idx_q <= '0;
            hold_q     <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            frame_q    <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            hold_q     <= hold_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            frame_q    <= frame_d;
        end
    end

    assign bus.byte_rd     = !w_full;
    assign bus.data_out_re = out_q.re;
    assign bus.data_out_im = out_q.im;
    assign bus.data_valid  = valid_q;
    assign bus.frame_last  = valid_q && (frame_q == C_FRAME_LAST);
    assign bus.buff_full   = w_full;
    assign bus.buff_empty  = w_empty;

endmodule
`default_nettype wire
